// File: rtl/ch_packer_pkg.sv
// Shared types and sizing helpers for the dequeue-side beat packer.
package ch_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_BEATS      = 4;
  localparam int WORD_WIDTH     = DEF_DATA_WIDTH * DEF_BEATS;
  localparam int CNT_WIDTH      = $clog2(DEF_BEATS + 1);

  function automatic int slot_lsb(input int idx, input int dw);
    return idx * dw;
  endfunction

endpackage

// File: rtl/ch_packer_slot_reg.sv
// One beat-wide slot of the packing register; write has priority over clear.
module ch_packer_slot_reg #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)      q <= '0;
    else if (wr_en) q <= d;
    else if (clr)   q <= '0;
  end

endmodule

// File: rtl/ch_deq_packer.sv
// Packs BEATS narrow beats into one wide word, with explicit flush of partial words.
// Optional idle auto-flush is compiled in with CH_PACKER_TIMEOUT_EN.
module ch_deq_packer
  import ch_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BEATS      = DEF_BEATS,
  parameter int TIMEOUT    = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_WIDTH*BEATS-1:0]   out_data,
  output logic [$clog2(BEATS+1)-1:0]    out_beats,
  input  logic                          out_ready
);

  localparam int CW = $clog2(BEATS + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] fill_cnt;
  logic          acc, do_flush, last_beat, go_hold, handshake;

  assign acc       = in_valid & in_ready;
  assign handshake = (state == HOLD) & out_ready;
  assign fill_cnt  = count + CW'(acc);
  assign last_beat = acc && (count == CW'(BEATS - 1));
  assign go_hold   = (state == FILL) && (last_beat || (do_flush && fill_cnt != '0));

`ifdef CH_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle;

  assign do_flush = flush | (idle == IW'(TIMEOUT));

  // Counts only while a partial word sits waiting; never exceeds TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset)
      idle <= '0;
    else if (state == FILL && count != '0 && !acc && !go_hold)
      idle <= idle + IW'(1);
    else
      idle <= '0;
  end
`else
  assign do_flush = flush;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (go_hold)   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state == HOLD) begin
      in_ready  = out_ready;
      out_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      out_beats <= '0;
    end else if (state == FILL) begin
      if (go_hold) begin
        count     <= '0;
        out_beats <= fill_cnt;
      end else begin
        count     <= fill_cnt;
      end
    end else if (out_ready) begin
      count     <= CW'(acc);
      out_beats <= '0;
    end
  end

  // The slot registers are out_data; in HOLD only the handshake can touch them.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic wr_en;
    if (gi == 0) begin : g_first
      assign wr_en = acc & ((state == HOLD) | (count == '0));
    end else begin : g_rest
      assign wr_en = acc & (state == FILL) & (count == CW'(gi));
    end

    ch_packer_slot_reg #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .wr_en (wr_en),
      .clr   (handshake),
      .d     (in_data),
      .q     (out_data[slot_lsb(gi, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_ch_deq_packer.sv
// Directed plus random stimulus against a queue-based model of the beat packer.
module tb_ch_deq_packer;
  import ch_packer_pkg::*;

  localparam int DW = 4;
  localparam int NB = 4;
  localparam int TO = 15;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic                  in_ready;
  logic                  flush;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_beats;
  logic                  out_ready;

  always #5 clk = ~clk;

  ch_deq_packer #(.DATA_WIDTH(DW), .BEATS(NB), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_beats (out_beats),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: beats collected so far, and the word currently offered downstream.
  logic [DW-1:0] cur[$];
  bit            held;
  logic [31:0]   held_word;
  int            held_beats;
  int            idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur.delete();
    held = 1'b0;
    idle = 0;
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit f, input bit r);
    bit exp_rdy, acc, tflush, fill_go;
    int pre;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
    exp_rdy = held ? r : 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    tflush = 1'b0;
`ifdef CH_PACKER_TIMEOUT_EN
    tflush = !held && (idle == TO);
`endif
    @(posedge clk);
    pre = cur.size();
    if (held) begin
      if (r) begin
        held = 1'b0;
        cur.delete();
        if (acc) cur.push_back(d);
      end
      idle = 0;
    end else begin
      if (acc) cur.push_back(d);
      fill_go = (cur.size() == NB) || ((f || tflush) && cur.size() > 0);
      idle = (pre > 0 && !acc && !fill_go) ? idle + 1 : 0;
      if (fill_go) begin
        held = 1'b1;
        held_word = '0;
        foreach (cur[i]) held_word |= 32'(cur[i]) << (DW * i);
        held_beats = cur.size();
        cur.delete();
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(held));
    if (held) begin
      chk("out_data", 32'(out_data), held_word);
      chk("out_beats", 32'(out_beats), 32'(held_beats));
    end
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_beats", 32'(out_beats), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Four back-to-back beats, word held exactly one cycle.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    chk("t1_data", 32'(out_data), 32'h4321);
    chk("t1_beats", 32'(out_beats), 32'd4);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("t1_one_cycle", 32'(out_valid), 32'd0);

    // Backpressure: word stays put, concurrent beat lands in slot 0 at handshake.
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'hA, 1'b0, 1'b0);
      chk("t2_stable", 32'(out_data), 32'h4321);
    end
    cycle(1'b1, 4'hA, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t2_next_slot0", 32'(out_data), 32'h000A);
    chk("t2_next_beats", 32'(out_beats), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Flush of a partial word, then a flush with nothing collected.
    cycle(1'b1, 4'h5, 1'b0, 1'b1);
    cycle(1'b1, 4'h6, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t3_data", 32'(out_data), 32'h0065);
    chk("t3_beats", 32'(out_beats), 32'd2);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("t3_empty_flush", 32'(out_valid), 32'd0);

    // Beat and flush in the same cycle.
    cycle(1'b1, 4'h5, 1'b0, 1'b1);
    cycle(1'b1, 4'h6, 1'b0, 1'b1);
    cycle(1'b1, 4'h7, 1'b1, 1'b1);
    chk("t4_data", 32'(out_data), 32'h0765);
    chk("t4_beats", 32'(out_beats), 32'd3);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset discards a partial word.
    cycle(1'b1, 4'h8, 1'b0, 1'b1);
    cycle(1'b1, 4'h9, 1'b0, 1'b1);
    cycle(1'b1, 4'hA, 1'b0, 1'b1);
    do_reset();
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    for (int i = 8; i <= 11; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1);
    chk("t5_data", 32'(out_data), 32'hBA98);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Single beat left idle.
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
`ifdef CH_PACKER_TIMEOUT_EN
    for (int i = 0; i < TO; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t6_not_yet", 32'(out_valid), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t6_timeout_valid", 32'(out_valid), 32'd1);
    chk("t6_timeout_data", 32'(out_data), 32'h000C);
    chk("t6_timeout_beats", 32'(out_beats), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1);
`else
    for (int i = 0; i < 100; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("t6_no_timeout", 32'(out_valid), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("t6_flush_data", 32'(out_data), 32'h000C);
    cycle(1'b0, '0, 1'b0, 1'b1);
`endif

    // Random traffic, including idle stretches long enough for auto-flush.
    for (int i = 0; i < 600; i++) begin
      bit v, f, r;
      v = (i % 100 < 70) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 3) != 0);
      cycle(v, DW'($urandom), f, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
